// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the busctl memory port between up to four requesters.
// Optional macro BUS_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead.
module bus_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [17*NUM_REQ-1:0]  req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rvalid,
  output logic [7:0]             rdata,
  output logic                   busy,
  output logic                   bus_we,
  output logic [16:0]            bus_addr,
  output logic [7:0]             bus_wdata,
  input  logic [7:0]             bus_rdata,
  output logic [1:0]             dbg_state
);
  localparam int         IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IW-1:0]        r_idx;
  logic [2:0]           r_cnt;
  logic [NUM_REQ-1:0]   r_gnt, r_rvalid;
  logic [7:0]           r_rdata, r_bus_wdata;
  logic                 r_busy, r_bus_we;
  logic [16:0]          r_bus_addr;
`ifndef BUS_ARB_FIXED_PRIO_EN
  logic [IW-1:0]        r_last;
`endif

  logic                 w_found;
  logic [IW-1:0]        w_win;
  logic                 w_we;
  logic [16:0]          w_addr;
  logic [7:0]           w_wdata;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] k);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int j = 0; j < NUM_REQ; j++) v[j] = (IW'(j) == k);
    return v;
  endfunction

  // Round-robin: first set bit above last, otherwise wrap to the lowest set bit.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req[j] && (IW'(j) > r_last)) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end
    end
`endif
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IW'(j) == w_win) begin
        w_we    = req_we[j];
        w_addr  = req_addr[17*j +: 17];
        w_wdata = req_wdata[8*j +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = r_bus_we ? IDLE : WAIT;
      WAIT:    if (r_cnt == 3'd0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
      r_last      <= IW'(NUM_REQ - 1);
`endif
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          r_rvalid <= '0;
          if (w_found) begin
            r_idx       <= w_win;
            r_gnt       <= onehot(w_win);
            r_bus_we    <= w_we;
            r_bus_addr  <= w_addr;
            r_bus_wdata <= w_wdata;
`ifndef BUS_ARB_FIXED_PRIO_EN
            r_last      <= w_win;
`endif
          end
        end
        ISSUE: begin
          r_gnt    <= '0;
          r_bus_we <= 1'b0;
          r_cnt    <= LAT_M1;
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_rdata  <= bus_rdata;
            r_rvalid <= onehot(r_idx);
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: instance A (3 requesters, latency 1), instance B (2 requesters, latency 4).
module tb_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0]  a_req, a_req_we, a_gnt, a_rvalid;
  logic [50:0] a_req_addr;
  logic [23:0] a_req_wdata;
  logic [7:0]  a_rdata, a_bus_wdata, a_bus_rdata;
  logic        a_busy, a_bus_we;
  logic [16:0] a_bus_addr;
  logic [1:0]  a_state;

  logic [1:0]  b_req, b_req_we, b_gnt, b_rvalid;
  logic [33:0] b_req_addr;
  logic [15:0] b_req_wdata;
  logic [7:0]  b_rdata, b_bus_wdata, b_bus_rdata;
  logic        b_busy, b_bus_we;
  logic [16:0] b_bus_addr;
  logic [1:0]  b_state;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.NUM_REQ(3), .READ_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .req_we(a_req_we), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .busy(a_busy),
    .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata),
    .dbg_state(a_state));

  bus_arbiter #(.NUM_REQ(2), .READ_LAT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_we(b_req_we), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .busy(b_busy),
    .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata),
    .dbg_state(b_state));

  // Memory contents are a fixed function of the address; 0x00010 holds 0xC3.
  function automatic logic [7:0] mem_f(input logic [16:0] ad);
    return ad[7:0] ^ ad[15:8] ^ 8'hD3;
  endfunction

  always @(posedge clk) a_bus_rdata <= mem_f(a_bus_addr);

  logic [7:0] b_pipe [4];
  always @(posedge clk) begin
    b_pipe[0] <= mem_f(b_bus_addr);
    for (int k = 1; k < 4; k++) b_pipe[k] <= b_pipe[k-1];
  end
  assign b_bus_rdata = b_pipe[3];

  typedef struct {
    bit          sel;
    int          idx;
    bit          we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  exp_gnt;
    int          exp_lat;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cur_gnt(input bit sel);
    return sel ? {2'b00, b_gnt} : {1'b0, a_gnt};
  endfunction
  function automatic logic [3:0] cur_rvalid(input bit sel);
    return sel ? {2'b00, b_rvalid} : {1'b0, a_rvalid};
  endfunction
  function automatic logic [7:0] cur_rdata(input bit sel);
    return sel ? b_rdata : a_rdata;
  endfunction
  function automatic logic cur_we(input bit sel);
    return sel ? b_bus_we : a_bus_we;
  endfunction
  function automatic logic cur_busy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction
  function automatic logic [16:0] cur_addr(input bit sel);
    return sel ? b_bus_addr : a_bus_addr;
  endfunction
  function automatic logic [7:0] cur_wdata(input bit sel);
    return sel ? b_bus_wdata : a_bus_wdata;
  endfunction

  task automatic set_req(input bit sel, input int idx, input bit v, input bit we,
                         input logic [16:0] ad, input logic [7:0] wd);
    if (sel) begin
      b_req[idx] = v; b_req_we[idx] = we;
      b_req_addr[17*idx +: 17] = ad; b_req_wdata[8*idx +: 8] = wd;
    end else begin
      a_req[idx] = v; a_req_we[idx] = we;
      a_req_addr[17*idx +: 17] = ad; a_req_wdata[8*idx +: 8] = wd;
    end
  endtask

  task automatic do_txn(input vec_t v);
    int n;
    logic [3:0] g;
    set_req(v.sel, v.idx, 1'b1, v.we, v.addr, v.wdata);
    n = 0;
    g = 4'd0;
    while (g == 4'd0 && n < 20) begin
      tick(); n++;
      g = cur_gnt(v.sel);
    end
    chk("gnt", g, v.exp_gnt);
    chk("gnt_lat", n, 1);
    chk("bus_we_issue", cur_we(v.sel), v.we);
    chk("bus_addr", cur_addr(v.sel), v.addr);
    chk("busy_issue", cur_busy(v.sel), 1'b1);
    if (v.we) chk("bus_wdata", cur_wdata(v.sel), v.wdata);
    set_req(v.sel, v.idx, 1'b0, 1'b0, 17'h0, 8'h0);
    tick(); n++;
    chk("gnt_pulse", cur_gnt(v.sel), 4'd0);
    chk("bus_we_drop", cur_we(v.sel), 1'b0);
    if (!v.we) begin
      while (cur_rvalid(v.sel) == 4'd0 && n < 20) begin
        chk("bus_we_wait", cur_we(v.sel), 1'b0);
        tick(); n++;
      end
      chk("rvalid", cur_rvalid(v.sel), v.exp_gnt);
      chk("rd_lat", n, v.exp_lat);
      chk("rdata", cur_rdata(v.sel), v.exp_rdata);
      tick();
      chk("rvalid_pulse", cur_rvalid(v.sel), 4'd0);
    end
    chk("busy_end", cur_busy(v.sel), 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_g;
    bit seen;
    int g0_c, g1_c, rv0_c, rv1_c;
    logic [7:0] rd0, rd1;
    logic we_seen;

    vecs[0] = '{1'b0, 0, 1'b1, 17'h1ABCD, 8'h5A, 4'b0001, 1, 8'h00};
    vecs[1] = '{1'b0, 1, 1'b0, 17'h00010, 8'h00, 4'b0010, 3, 8'hC3};
    vecs[2] = '{1'b0, 2, 1'b1, 17'h00F0F, 8'hA5, 4'b0100, 1, 8'h00};
    vecs[3] = '{1'b0, 2, 1'b0, 17'h12345, 8'h00, 4'b0100, 3, 8'hB5};
    vecs[4] = '{1'b0, 0, 1'b0, 17'h1FFFF, 8'h00, 4'b0001, 3, 8'hD3};
    vecs[5] = '{1'b1, 1, 1'b0, 17'h00010, 8'h00, 4'b0010, 6, 8'hC3};
    vecs[6] = '{1'b1, 0, 1'b1, 17'h00000, 8'hFF, 4'b0001, 1, 8'h00};
    vecs[7] = '{1'b1, 0, 1'b0, 17'h0AB00, 8'h00, 4'b0001, 6, 8'h78};

    rst_n = 1'b0;
    a_req = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0;
    b_req = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0;
    tick(); tick();
    chk("rst_a", {a_gnt, a_rvalid, a_rdata, a_busy, a_bus_we, a_bus_addr, a_bus_wdata, a_state}, 64'd0);
    chk("rst_b", {b_gnt, b_rvalid, b_rdata, b_busy, b_bus_we, b_bus_addr, b_bus_wdata, b_state}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Reset in the middle of a latency-4 read: outputs clear at once, no late rvalid.
    set_req(1'b1, 0, 1'b1, 1'b0, 17'h00055, 8'h00);
    tick();
    chk("mid_gnt", b_gnt, 2'b01);
    set_req(1'b1, 0, 1'b0, 1'b0, 17'h0, 8'h0);
    tick();
    chk("mid_state_wait", b_state, 2'd2);
    chk("mid_busy", b_busy, 1'b1);
    chk("mid_addr_hold", b_bus_addr, 17'h00055);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b", {b_gnt, b_rvalid, b_rdata, b_busy, b_bus_we, b_bus_addr, b_bus_wdata, b_state}, 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (b_rvalid != 2'b00 || b_busy) seen = 1'b1;
    end
    chk("no_rvalid_after_rst", seen, 1'b0);

    // All three requesters on A write continuously.
    for (int i = 0; i < 3; i++) set_req(1'b0, i, 1'b1, 1'b1, 17'(i + 32'h100), 8'(i + 32'h10));
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef BUS_ARB_FIXED_PRIO_EN
      exp_g = (c % 2 == 1) ? 3'b001 : 3'b000;
`else
      exp_g = (c % 2 == 1) ? (3'b001 << (((c - 1) / 2) % 3)) : 3'b000;
`endif
      chk($sformatf("rr_gnt_c%0d", c), a_gnt, exp_g);
      chk($sformatf("rr_we_c%0d", c), a_bus_we, exp_g != 3'b000);
    end
    a_req = '0;
    tick(); tick();

    // Back-to-back reads from both requesters of B.
    g0_c = -1; g1_c = -1; rv0_c = -1; rv1_c = -1; rd0 = 8'h00; rd1 = 8'h00; we_seen = 1'b0;
    set_req(1'b1, 0, 1'b1, 1'b0, 17'h00123, 8'h00);
    set_req(1'b1, 1, 1'b1, 1'b0, 17'h04588, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (b_gnt[0]) begin g0_c = c; set_req(1'b1, 0, 1'b0, 1'b0, 17'h0, 8'h0); end
      if (b_gnt[1]) begin g1_c = c; set_req(1'b1, 1, 1'b0, 1'b0, 17'h0, 8'h0); end
      if (b_rvalid[0]) begin rv0_c = c; rd0 = b_rdata; end
      if (b_rvalid[1]) begin rv1_c = c; rd1 = b_rdata; end
      if (b_bus_we) we_seen = 1'b1;
    end
    chk("b2b_gnt0_cycle", g0_c, 1);
    chk("b2b_rvalid0_cycle", rv0_c, 6);
    chk("b2b_rdata0", rd0, 8'hF1);
    chk("b2b_gnt1_cycle", g1_c, 7);
    chk("b2b_rvalid1_cycle", rv1_c, 12);
    chk("b2b_rdata1", rd1, 8'h1E);
    chk("b2b_bus_we_low", we_seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single `busctl` memory port (17-bit address, 8-bit data, synchronous `memctl` behind it) between up to four requesters, e.g. CPU, DMA and video fetch. Each requester runs a req/gnt handshake. The arbiter serialises accepted transactions onto the bus, waits out the read latency, and returns read data with a one-cycle valid strobe to the owning requester. It sits directly in front of `busctl` and is the only driver of its `write_en`/`addr_in`/`data_in`.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 1–4.
- `READ_LAT`, 1: cycles from bus address presentation to valid `bus_rdata`, legal range 1–7.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req` in NUM_REQ: per-requester request level.
- `req_we` in NUM_REQ: per-requester write (1) or read (0).
- `req_addr` in 17*NUM_REQ: packed addresses; requester i uses `[17*i +: 17]`.
- `req_wdata` in 8*NUM_REQ: packed write data; requester i uses `[8*i +: 8]`.
- `gnt` out NUM_REQ: one-cycle accept pulse, at most one bit set.
- `rvalid` out NUM_REQ: one-cycle read-data-valid pulse, at most one bit set.
- `rdata` out 8: read data, shared by all requesters and qualified by `rvalid`.
- `busy` out 1: high whenever the state is not IDLE.
- `bus_we` out 1: to `busctl.write_en`.
- `bus_addr` out 17: to `busctl.addr_in`.
- `bus_wdata` out 8: to `busctl.data_in`.
- `bus_rdata` in 8: from `busctl.data_out`.

## Operation
- **States:**
  - IDLE → ISSUE when any `req` bit is high.
  - ISSUE → IDLE for a write.
  - ISSUE → WAIT for a read.
  - WAIT → IDLE after READ_LAT cycles.
- **IDLE:** sample `req` and select a winner. On the IDLE→ISSUE edge, latch the winner's index, `req_we`, `req_addr` and `req_wdata` into registers.
- **ISSUE** (exactly one cycle):
  - `bus_addr`/`bus_wdata` show the latched values.
  - `bus_we` = latched we.
  - `gnt[winner]` = 1.
  - After this cycle the requester may change or drop its fields.
- **WAIT:**
  - A 3-bit counter loads READ_LAT-1 on entry and decrements each cycle.
  - `bus_addr` holds the latched address; `bus_we` = 0.
  - When the counter reaches 0, capture `bus_rdata` into `rdata` and pulse `rvalid[winner]` on the following cycle, coincident with the return to IDLE.
- **Round-robin:**
  - Search starts at `last+1` mod NUM_REQ; the first set `req` bit wins.
  - `last` updates to the winner on entering ISSUE.
  - Reset sets `last` = NUM_REQ-1, so requester 0 has first priority.
- **Requester rules:**
  - A requester holds `req`, `req_we`, `req_addr` and `req_wdata` stable until it sees `gnt`.
  - Dropping `req` before the arbiter samples it in IDLE means no transaction is performed.
  - `req` still high in the cycle after `gnt` is treated as a new request.
- **Out-of-range index:** requesters with index ≥ NUM_REQ do not exist. All bits of `gnt` and `rvalid` are driven 0 outside a pulse.
- **Mid-operation reset:** asynchronously returns the block to IDLE. Any pending read is abandoned with no `rvalid`.

## Timing
- **Reset values:** `gnt`=0, `rvalid`=0, `rdata`=0, `busy`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, state=IDLE, `last`=NUM_REQ-1.
- All outputs are registered.
- **Write:** `req` seen in IDLE at cycle T; ISSUE with `gnt`/`bus_we` at T+1; IDLE at T+2. Peak rate is one write per 2 cycles.
- **Read:** `req` at T; ISSUE at T+1; WAIT for T+2 … T+1+READ_LAT; `rvalid` at T+2+READ_LAT.
- `bus_we` is high only in ISSUE of a write, and never for more than one cycle per grant.
- **Simultaneous requests:** exactly one winner per IDLE cycle; the others remain pending.
- **Fairness:** with all requesters continuously requesting, grants rotate 0, 1, …, NUM_REQ-1, 0, …

## Configuration
- `BUS_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index always wins. The `last` register is not implemented.
- `BUS_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- **Reset:** assert `rst_n`=0 mid-read → all outputs 0 immediately; no `rvalid` after release; `busy`=0.
- **Single write:** requester 0 writes 0x1ABCD←0x5A → one-cycle `bus_we` with `bus_addr`=0x1ABCD and `bus_wdata`=0x5A; `gnt[0]` in the same cycle.
- **Single read:** READ_LAT=1, requester 1 reads 0x00010 with memory holding 0xC3 → `rvalid[1]` and `rdata`=0xC3 exactly 3 cycles after `req` is sampled.
- **Contention, round-robin:** NUM_REQ=3, all requesters issue continuous writes → `gnt` order 0, 1, 2, 0, 1, 2; one grant every 2 cycles.
- **Contention, fixed priority:** with `BUS_ARB_FIXED_PRIO_EN` defined, requesters 0 and 2 both continuously request → only `gnt[0]` is ever asserted.
- **Read latency sweep:** READ_LAT=4 with back-to-back reads from two requesters → each `rvalid` arrives 6 cycles after its `req` is sampled, and `bus_we` stays 0 throughout.
